// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller: stage enables, flushes, EX operand bypass, multi-cycle stall.
// Optional perf counters are built only when HAZ_PERF_EN is defined.
module pipe_hazard_unit #(
  parameter int DWIDTH  = 32,
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1_id,
  input  logic [REG_AW-1:0] id_rs2_id,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rs1_id,
  input  logic [REG_AW-1:0] ex_rs2_id,
  input  logic [DWIDTH-1:0] ex_rs1_raw,
  input  logic [DWIDTH-1:0] ex_rs2_raw,
  input  logic [REG_AW-1:0] ex_rdst_id,
  input  logic              ex_we_reg,
  input  logic              ex_mem_read,
  input  logic              ex_is_mul,
  input  logic              ex_redirect,
  input  logic [REG_AW-1:0] mem_rdst_id,
  input  logic              mem_we_reg,
  input  logic [DWIDTH-1:0] mem_fwd_data,
  input  logic [REG_AW-1:0] wb_rdst_id,
  input  logic              wb_we_reg,
  input  logic [DWIDTH-1:0] wb_fwd_data,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic [DWIDTH-1:0] ex_rs1_fwd,
  output logic [DWIDTH-1:0] ex_rs2_fwd,
  output logic [1:0]        fwd_sel1,
  output logic [1:0]        fwd_sel2,
  output logic              mul_done,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LAT - 1);

  typedef enum logic {IDLE, BUSY} mul_state_e;

  mul_state_e  state;
  logic [CW-1:0] cnt;
  logic        mul_stall;
  logic        redirect_acc;
  logic        load_use;

  assign mul_stall    = ex_valid && ex_is_mul && (cnt != CNT_LAST);
  assign mul_done     = ex_valid && ex_is_mul && (cnt == CNT_LAST);
  assign redirect_acc = ex_redirect && !mul_stall;
  assign load_use     = ex_valid && ex_mem_read && ex_we_reg && (ex_rdst_id != '0) &&
                        ((id_rs1_used && (id_rs1_id == ex_rdst_id)) ||
                         (id_rs2_used && (id_rs2_id == ex_rdst_id)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mul_stall) begin
            cnt   <= cnt + 1'b1;
            state <= BUSY;
          end else begin
            cnt <= '0;
          end
        end
        BUSY: begin
          if (mul_stall) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Priority: multi-cycle stall, then redirect (squashes the dependent), then load-use.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (mul_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_flush = 1'b1;
    end else if (redirect_acc) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_comb begin
    fwd_sel1 = 2'b00;
    if (mem_we_reg && (mem_rdst_id == ex_rs1_id) && (ex_rs1_id != '0)) begin
      fwd_sel1 = 2'b01;
    end else if (wb_we_reg && (wb_rdst_id == ex_rs1_id) && (ex_rs1_id != '0)) begin
      fwd_sel1 = 2'b10;
    end
    fwd_sel2 = 2'b00;
    if (mem_we_reg && (mem_rdst_id == ex_rs2_id) && (ex_rs2_id != '0)) begin
      fwd_sel2 = 2'b01;
    end else if (wb_we_reg && (wb_rdst_id == ex_rs2_id) && (ex_rs2_id != '0)) begin
      fwd_sel2 = 2'b10;
    end
  end

  always_comb begin
    case (fwd_sel1)
      2'b01:   ex_rs1_fwd = mem_fwd_data;
      2'b10:   ex_rs1_fwd = wb_fwd_data;
      default: ex_rs1_fwd = ex_rs1_raw;
    endcase
    case (fwd_sel2)
      2'b01:   ex_rs2_fwd = mem_fwd_data;
      2'b10:   ex_rs2_fwd = wb_fwd_data;
      default: ex_rs2_fwd = ex_rs2_raw;
    endcase
  end

`ifdef HAZ_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (redirect_acc && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: vector table plus multiply/reset sequences.
module tb_pipe_hazard_unit;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int ML = 3;
  localparam int CNW = 32;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] id_rs1_id, id_rs2_id, ex_rs1_id, ex_rs2_id, ex_rdst_id, mem_rdst_id, wb_rdst_id;
  logic id_rs1_used, id_rs2_used, ex_valid, ex_we_reg, ex_mem_read, ex_is_mul, ex_redirect;
  logic mem_we_reg, wb_we_reg;
  logic [DW-1:0] ex_rs1_raw, ex_rs2_raw, mem_fwd_data, wb_fwd_data;
  logic pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush, mul_done;
  logic [DW-1:0] ex_rs1_fwd, ex_rs2_fwd;
  logic [1:0] fwd_sel1, fwd_sel2;
  logic [CNW-1:0] stall_cycles, flush_events;

  always #5 clk = ~clk;

  pipe_hazard_unit #(.DWIDTH(DW), .REG_AW(AW), .MUL_LAT(ML), .CNT_W(CNW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_id(id_rs1_id), .id_rs2_id(id_rs2_id),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_valid(ex_valid), .ex_rs1_id(ex_rs1_id), .ex_rs2_id(ex_rs2_id),
    .ex_rs1_raw(ex_rs1_raw), .ex_rs2_raw(ex_rs2_raw),
    .ex_rdst_id(ex_rdst_id), .ex_we_reg(ex_we_reg), .ex_mem_read(ex_mem_read),
    .ex_is_mul(ex_is_mul), .ex_redirect(ex_redirect),
    .mem_rdst_id(mem_rdst_id), .mem_we_reg(mem_we_reg), .mem_fwd_data(mem_fwd_data),
    .wb_rdst_id(wb_rdst_id), .wb_we_reg(wb_we_reg), .wb_fwd_data(wb_fwd_data),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .ex_rs1_fwd(ex_rs1_fwd), .ex_rs2_fwd(ex_rs2_fwd),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .mul_done(mul_done),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  typedef struct packed {
    logic [AW-1:0] id_rs1_id, id_rs2_id;
    logic id_rs1_used, id_rs2_used, ex_valid;
    logic [AW-1:0] ex_rs1_id, ex_rs2_id;
    logic [DW-1:0] ex_rs1_raw, ex_rs2_raw;
    logic [AW-1:0] ex_rdst_id;
    logic ex_we_reg, ex_mem_read, ex_is_mul, ex_redirect;
    logic [AW-1:0] mem_rdst_id;
    logic mem_we_reg;
    logic [DW-1:0] mem_fwd_data;
    logic [AW-1:0] wb_rdst_id;
    logic wb_we_reg;
    logic [DW-1:0] wb_fwd_data;
  } in_t;

  typedef struct packed {
    logic pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush;
    logic [1:0] sel1, sel2;
    logic [DW-1:0] fwd1, fwd2;
    logic mul_done;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  int total = 0;
  int bad = 0;
  out_t sbq[$];
  logic [CNW-1:0] exp_stall = '0;
  logic [CNW-1:0] exp_flush = '0;

  task automatic drive(input in_t v);
    id_rs1_id = v.id_rs1_id;     id_rs2_id = v.id_rs2_id;
    id_rs1_used = v.id_rs1_used; id_rs2_used = v.id_rs2_used;
    ex_valid = v.ex_valid;       ex_rs1_id = v.ex_rs1_id;   ex_rs2_id = v.ex_rs2_id;
    ex_rs1_raw = v.ex_rs1_raw;   ex_rs2_raw = v.ex_rs2_raw;
    ex_rdst_id = v.ex_rdst_id;   ex_we_reg = v.ex_we_reg;   ex_mem_read = v.ex_mem_read;
    ex_is_mul = v.ex_is_mul;     ex_redirect = v.ex_redirect;
    mem_rdst_id = v.mem_rdst_id; mem_we_reg = v.mem_we_reg; mem_fwd_data = v.mem_fwd_data;
    wb_rdst_id = v.wb_rdst_id;   wb_we_reg = v.wb_we_reg;   wb_fwd_data = v.wb_fwd_data;
  endtask

  function automatic out_t sample();
    out_t s;
    s.pc_write = pc_write;     s.ifid_write = ifid_write;   s.idex_write = idex_write;
    s.ifid_flush = ifid_flush; s.idex_flush = idex_flush;   s.exmem_flush = exmem_flush;
    s.sel1 = fwd_sel1;         s.sel2 = fwd_sel2;
    s.fwd1 = ex_rs1_fwd;       s.fwd2 = ex_rs2_fwd;         s.mul_done = mul_done;
    return s;
  endfunction

  function automatic in_t idle_in();
    in_t v;
    v = '0;
    v.ex_rs1_raw = 32'h0000_AAAA;
    v.ex_rs2_raw = 32'h0000_BBBB;
    v.mem_fwd_data = 32'h0000_1111;
    v.wb_fwd_data = 32'h0000_2222;
    return v;
  endfunction

  function automatic out_t base_out(input in_t v);
    out_t o;
    o = '0;
    o.pc_write = 1'b1; o.ifid_write = 1'b1; o.idex_write = 1'b1;
    o.fwd1 = v.ex_rs1_raw; o.fwd2 = v.ex_rs2_raw;
    return o;
  endfunction

  function automatic out_t stall_out(input in_t v);
    out_t o;
    o = base_out(v);
    o.pc_write = 1'b0; o.ifid_write = 1'b0; o.idex_write = 1'b0; o.exmem_flush = 1'b1;
    return o;
  endfunction

  // Inputs are already driven; expectation is queued, checked mid-cycle, then the edge is taken.
  task automatic chk_cycle(input string name, input out_t e, input bit redir);
    out_t got, ex;
    sbq.push_back(e);
    @(negedge clk);
    got = sample();
    ex = sbq.pop_front();
    total++;
    if (got !== ex) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, ex);
    end
    @(posedge clk);
    if (rst) begin
      if (!e.pc_write) exp_stall++;
      if (redir) exp_flush++;
    end
    #1;
  endtask

  task automatic chk_perf(input string name);
    logic [CNW-1:0] es, ef;
`ifdef HAZ_PERF_EN
    es = exp_stall;
    ef = exp_flush;
`else
    es = '0;
    ef = '0;
`endif
    total++;
    if (stall_cycles !== es) begin
      bad++;
      $display("FAIL %s_stall got=%0d exp=%0d", name, stall_cycles, es);
    end
    total++;
    if (flush_events !== ef) begin
      bad++;
      $display("FAIL %s_flush got=%0d exp=%0d", name, flush_events, ef);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    in_t v, mul_in, mul_rd;
    out_t o, o_stall, o_done;

    v = idle_in(); o = base_out(v);
    tbl[0] = '{"idle", v, o};

    v = idle_in(); v.mem_we_reg = 1; v.mem_rdst_id = 3; v.wb_we_reg = 1; v.wb_rdst_id = 3;
    v.ex_rs1_id = 3; v.ex_rs2_id = 4;
    o = base_out(v); o.sel1 = 2'b01; o.fwd1 = 32'h1111;
    tbl[1] = '{"mem_over_wb", v, o};

    v = idle_in(); v.mem_we_reg = 1; v.mem_rdst_id = 0; v.ex_rs2_id = 0; v.ex_rs2_raw = 0;
    v.ex_rs1_id = 7; v.ex_rs1_raw = 32'h77;
    o = base_out(v);
    tbl[2] = '{"x0_guard", v, o};

    v = idle_in(); v.wb_we_reg = 1; v.wb_rdst_id = 9; v.wb_fwd_data = 32'h9999;
    v.mem_we_reg = 1; v.mem_rdst_id = 8; v.ex_rs2_id = 9;
    o = base_out(v); o.sel2 = 2'b10; o.fwd2 = 32'h9999;
    tbl[3] = '{"wb_only", v, o};

    v = idle_in(); v.mem_we_reg = 0; v.mem_rdst_id = 5; v.ex_rs1_id = 5;
    o = base_out(v);
    tbl[4] = '{"mem_we_off", v, o};

    v = idle_in(); v.ex_valid = 1; v.ex_mem_read = 1; v.ex_we_reg = 1; v.ex_rdst_id = 5;
    v.id_rs2_id = 5; v.id_rs2_used = 1;
    o = base_out(v); o.pc_write = 0; o.ifid_write = 0; o.idex_flush = 1;
    tbl[5] = '{"load_use", v, o};

    v = idle_in(); v.ex_valid = 1; v.ex_mem_read = 1; v.ex_we_reg = 1; v.ex_rdst_id = 5;
    v.id_rs2_id = 5; v.id_rs2_used = 0;
    o = base_out(v);
    tbl[6] = '{"load_unused", v, o};

    v = idle_in(); v.ex_valid = 1; v.ex_mem_read = 1; v.ex_we_reg = 1; v.ex_rdst_id = 0;
    v.id_rs1_id = 0; v.id_rs1_used = 1;
    o = base_out(v);
    tbl[7] = '{"load_x0", v, o};

    v = idle_in(); v.ex_valid = 1; v.ex_mem_read = 1; v.ex_we_reg = 1; v.ex_rdst_id = 5;
    v.id_rs1_id = 5; v.id_rs1_used = 1; v.ex_redirect = 1;
    o = base_out(v); o.ifid_flush = 1; o.idex_flush = 1;
    tbl[8] = '{"redir_masks_lu", v, o};

    v = idle_in(); v.ex_valid = 0; v.ex_mem_read = 1; v.ex_we_reg = 1; v.ex_rdst_id = 6;
    v.id_rs1_id = 6; v.id_rs1_used = 1;
    o = base_out(v);
    tbl[9] = '{"load_bubble", v, o};

    mul_in = idle_in(); mul_in.ex_valid = 1; mul_in.ex_is_mul = 1; mul_in.ex_we_reg = 1;
    mul_in.ex_rdst_id = 6; mul_in.ex_rs1_id = 3; mul_in.mem_we_reg = 1; mul_in.mem_rdst_id = 3;
    mul_rd = mul_in; mul_rd.ex_redirect = 1;
    o_stall = stall_out(mul_in); o_stall.sel1 = 2'b01; o_stall.fwd1 = 32'h1111;
    o_done = base_out(mul_in); o_done.sel1 = 2'b01; o_done.fwd1 = 32'h1111; o_done.mul_done = 1;

    rst = 1'b0;
    drive(idle_in());
    #1;
    chk_cycle("reset_state", base_out(idle_in()), 1'b0);
    chk_perf("reset_perf");
    rst = 1'b1;

    for (int k = 0; k < 10; k++) begin
      drive(tbl[k].i);
      chk_cycle(tbl[k].name, tbl[k].o, tbl[k].i.ex_redirect);
    end
    drive(idle_in());
    chk_cycle("post_table_idle", base_out(idle_in()), 1'b0);
    chk_perf("table_perf");

    drive(mul_in);
    chk_cycle("mul_c1", o_stall, 1'b0);
    drive(mul_rd);
    chk_cycle("mul_c2_redir_ignored", o_stall, 1'b0);
    drive(mul_in);
    chk_cycle("mul_done", o_done, 1'b0);
    chk_cycle("mul2_c1", o_stall, 1'b0);
    chk_cycle("mul2_c2", o_stall, 1'b0);
    chk_cycle("mul2_done", o_done, 1'b0);
    drive(idle_in());
    chk_cycle("post_mul_idle", base_out(idle_in()), 1'b0);
    chk_perf("mul_perf");

    drive(mul_in);
    chk_cycle("rmul_c1", o_stall, 1'b0);
    rst = 1'b0;
    drive(idle_in());
    exp_stall = '0;
    exp_flush = '0;
    chk_cycle("reset_in_busy", base_out(idle_in()), 1'b0);
    chk_perf("reset_busy_perf");
    rst = 1'b1;
    drive(mul_in);
    chk_cycle("rmul2_c1", o_stall, 1'b0);
    chk_cycle("rmul2_c2", o_stall, 1'b0);
    chk_cycle("rmul2_done", o_done, 1'b0);
    drive(idle_in());
    chk_cycle("final_idle", base_out(idle_in()), 1'b0);
    chk_perf("final_perf");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard and forwarding controller for the 5-stage pipelined core (IF/ID/EX/MEM/WB). It replaces the fixed-width hazard control and the absent EX-stage bypass. It generates the PC/IFID/IDEX write-enables, the stage flushes and EX operand forwarding. It adds a counter-driven stall for multi-cycle EX operations (multiply) and optional performance counters. It sits between the decode stage, the IDEX/EXMEM/MEMWB pipeline registers and the ALU operand muxes in `core_top`.

## Interface
Parameters:
- `DWIDTH`, 32, datapath width.
- `REG_AW`, 5, register-id width; register 0 is hard-wired zero.
- `MUL_LAT`, 3, EX-stage cycles a multi-cycle op occupies (≥1).
- `CNT_W`, 32, perf counter width (used only with `HAZ_PERF_EN`).

Ports:
- `clk` in 1 — clock, rising edge.
- `rst` in 1 — asynchronous, active-low reset.
- `id_rs1_id`, `id_rs2_id` in REG_AW — source ids of the instruction in ID.
- `id_rs1_used`, `id_rs2_used` in 1 — ID instruction actually reads that source.
- `ex_valid` in 1 — EX holds a real (non-bubble) instruction.
- `ex_rs1_id`, `ex_rs2_id` in REG_AW — EX source ids.
- `ex_rs1_raw`, `ex_rs2_raw` in DWIDTH — EX operands from IDEX.
- `ex_rdst_id` in REG_AW, `ex_we_reg` in 1, `ex_mem_read` in 1, `ex_is_mul` in 1 — EX destination info.
- `ex_redirect` in 1 — taken branch / J / JAL / JR resolved in EX this cycle.
- `mem_rdst_id` in REG_AW, `mem_we_reg` in 1, `mem_fwd_data` in DWIDTH — MEM writeback value (post wbsel mux).
- `wb_rdst_id` in REG_AW, `wb_we_reg` in 1, `wb_fwd_data` in DWIDTH — WB writeback value.
- `pc_write`, `ifid_write`, `idex_write` out 1 — stage write-enables.
- `ifid_flush`, `idex_flush`, `exmem_flush` out 1 — insert bubble into that register on next edge.
- `ex_rs1_fwd`, `ex_rs2_fwd` out DWIDTH — forwarded EX operands.
- `fwd_sel1`, `fwd_sel2` out 2 — 00 raw, 01 MEM, 10 WB.
- `mul_done` out 1 — last EX cycle of a multi-cycle op.
- `stall_cycles`, `flush_events` out CNT_W — perf counters (`HAZ_PERF_EN` only).

## Operation
- Forwarding (combinational, per operand n):
  - MEM is selected if `mem_we_reg && mem_rdst_id==ex_rsn_id && ex_rsn_id!=0`.
  - Otherwise WB is selected under the same rule with the wb signals.
  - Otherwise raw.
  - MEM has priority over WB.
- Load-use: `ex_valid && ex_mem_read && ex_we_reg && ex_rdst_id!=0` and an ID source (with its `used` bit set) equals `ex_rdst_id`.
  - Response: `pc_write=0`, `ifid_write=0`, `idex_flush=1` for exactly one cycle.
- Redirect: when `ex_redirect` is accepted, `ifid_flush=1` and `idex_flush=1`; `pc_write` stays 1.
- Multi-cycle op, FSM IDLE/BUSY with counter `cnt` (width clog2(MUL_LAT), min 1):
  - `mul_stall = ex_valid && ex_is_mul && cnt != MUL_LAT-1`.
  - While `mul_stall`: `pc_write=ifid_write=idex_write=0`, `exmem_flush=1`, and `cnt` increments (state BUSY once cnt>0).
  - `mul_done = ex_valid && ex_is_mul && cnt==MUL_LAT-1`; on that cycle `cnt` returns to 0 (IDLE).
  - With `MUL_LAT=1` the unit never stalls; `mul_done` equals `ex_is_mul && ex_valid`.
- Priority: mul_stall > redirect > load-use.
  - A multiply never redirects, so `ex_redirect` is ignored while `mul_stall`.
  - Redirect masks load-use, because the dependent instruction is squashed.
- Idle defaults: all write-enables 1, all flushes 0.

## Timing
- Control and forwarding outputs are combinational from inputs and `cnt`; there are no registered outputs except the counters.
- Load-use costs 1 bubble. Redirect costs 2 squashed slots. A multiply costs MUL_LAT-1 stall cycles.
- Reset (`rst` low) asynchronously sets `cnt=0` (IDLE) and the perf counters to 0.
  - Resulting outputs with idle inputs: write-enables 1, flushes 0, `fwd_sel`=00, `ex_rsn_fwd=ex_rsn_raw`, `mul_done=0`.
- Reset mid-BUSY aborts the stall immediately; there is no residual state after release.
- A new multiply entering EX on the cycle after `mul_done` restarts from `cnt=0`.

## Configuration
- `HAZ_PERF_EN` defined:
  - `stall_cycles` increments every cycle `pc_write==0`.
  - `flush_events` increments every accepted redirect.
  - Both saturate at all-ones and clear on reset.
- Not defined: both counter ports are driven constant 0 and no counter flops are built.

## Test plan
- MEM+WB same target: `mem_we_reg=1`, `mem_rdst_id=3`, `mem_fwd_data=0x1111`, WB id 3 with `0x2222`, `ex_rs1_id=3` -> `ex_rs1_fwd=0x1111`, `fwd_sel1=01`.
- x0 guard: `mem_we_reg=1`, `mem_rdst_id=0`, `ex_rs2_id=0`, raw 0 -> `fwd_sel2=00`, `ex_rs2_fwd=0`.
- Load-use: EX load `rdst=5`, ID `rs2_id=5` with `used=1` -> one cycle of `pc_write=0`, `ifid_write=0`, `idex_flush=1`; then defaults.
- Multiply with `MUL_LAT=3`: mul held in EX -> 2 cycles of write-enables 0 and `exmem_flush=1`, `mul_done=1` on the 3rd cycle, `cnt` back to 0.
- Redirect plus load-use in the same cycle -> `ifid_flush=1`, `idex_flush=1`, `pc_write=1`, `ifid_write=1`; `flush_events` +1 with `HAZ_PERF_EN`.
- Reset during BUSY (cnt=1): drive `rst` low -> stall drops the same cycle, perf counters read 0; after release the same mul stalls the full 2 cycles again.
